// File: rtl/cacheline_burst_adapter.sv
// Cacheline (256-bit) to 64-bit burst memory adapter: one transaction in flight,
// line writes split into BEATS beats, read beats gathered into a line.
// Optional feature macro: CLADAPT_RADDR_CHECK_EN (filter read beats by bmem_raddr, sticky resp_err).
module cacheline_burst_adapter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned BEATS  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic                      req_read,
    input  logic                      req_write,
    input  logic [BEAT_W*BEATS-1:0]   req_wdata,
    output logic                      req_ready,
    output logic                      resp_valid,
    output logic [BEAT_W*BEATS-1:0]   resp_rdata,
    output logic                      resp_err,
    output logic [ADDR_W-1:0]         bmem_addr,
    output logic                      bmem_read,
    output logic                      bmem_write,
    output logic [BEAT_W-1:0]         bmem_wdata,
    input  logic                      bmem_ready,
    input  logic [ADDR_W-1:0]         bmem_raddr,
    input  logic [BEAT_W-1:0]         bmem_rdata,
    input  logic                      bmem_rvalid
);

    localparam int unsigned LINE_W = BEAT_W * BEATS;
    localparam int unsigned OFFS_W = $clog2(LINE_W / 8);
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_BURST,
        S_DONE
    } state_t;

    state_t                          r_state;
    logic [CNT_W-1:0]                r_cnt;
    logic [ADDR_W-1:0]               r_addr;
    logic [BEATS-1:0][BEAT_W-1:0]    r_wline;
    logic [BEATS-1:0][BEAT_W-1:0]    r_rline;
    logic                            r_req_ready;
    logic                            r_resp_valid;
    logic                            r_resp_err;
    logic                            r_bmem_read;
    logic                            r_bmem_write;
    logic [BEAT_W-1:0]               r_bmem_wdata;

    state_t                          w_state_nxt;
    logic [CNT_W-1:0]                w_cnt_nxt;
    logic [ADDR_W-1:0]               w_addr_nxt;
    logic [BEATS-1:0][BEAT_W-1:0]    w_wline_nxt;
    logic [BEATS-1:0][BEAT_W-1:0]    w_rline_nxt;
    logic                            w_err_nxt;
    logic                            w_beat_ok;
    logic                            w_last;
    logic [ADDR_W-1:0]               w_req_aligned;
    logic [BEAT_W-1:0]               w_wdata_nxt;
    logic                            w_unused;

    assign w_last        = (r_cnt == CNT_W'(BEATS - 1));
    assign w_req_aligned = {req_addr[ADDR_W-1:OFFS_W], OFFS_W'(0)};

`ifdef CLADAPT_RADDR_CHECK_EN
    assign w_unused = ^req_addr[OFFS_W-1:0];
`else
    assign w_unused = ^{bmem_raddr, req_addr[OFFS_W-1:0]};
`endif

    // Next-state, datapath and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_wline_nxt = r_wline;
        w_rline_nxt = r_rline;
        w_err_nxt   = r_resp_err;
        w_beat_ok   = 1'b1;
        w_wdata_nxt = '0;

`ifdef CLADAPT_RADDR_CHECK_EN
        w_beat_ok = (bmem_raddr == r_addr);
        if (bmem_rvalid && !((r_state == S_RD_WAIT) && w_beat_ok)) begin
            w_err_nxt = 1'b1;
        end
`else
        w_err_nxt = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                // Read has priority; a simultaneous write is not accepted
                if (req_read) begin
                    w_addr_nxt  = w_req_aligned;
                    w_state_nxt = S_RD_REQ;
                end else if (req_write) begin
                    w_addr_nxt  = w_req_aligned;
                    w_wline_nxt = req_wdata;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WR_BURST;
                end
            end
            S_RD_REQ: begin
                if (bmem_ready) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (bmem_rvalid && w_beat_ok) begin
                    w_rline_nxt[r_cnt] = bmem_rdata;
                    w_cnt_nxt          = r_cnt + CNT_W'(1);
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_WR_BURST: begin
                if (bmem_ready) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_state_nxt == S_WR_BURST) begin
            w_wdata_nxt = w_wline_nxt[w_cnt_nxt];
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wline      <= '0;
            r_rline      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_bmem_read  <= 1'b0;
            r_bmem_write <= 1'b0;
            r_bmem_wdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_addr       <= w_addr_nxt;
            r_wline      <= w_wline_nxt;
            r_rline      <= w_rline_nxt;
            r_req_ready  <= (w_state_nxt == S_IDLE);
            r_resp_valid <= (w_state_nxt == S_DONE);
            r_resp_err   <= w_err_nxt;
            r_bmem_read  <= (w_state_nxt == S_RD_REQ);
            r_bmem_write <= (w_state_nxt == S_WR_BURST);
            r_bmem_wdata <= w_wdata_nxt;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rline;
    assign resp_err   = r_resp_err;
    assign bmem_addr  = r_addr;
    assign bmem_read  = r_bmem_read;
    assign bmem_write = r_bmem_write;
    assign bmem_wdata = r_bmem_wdata;

endmodule
